// File: rtl/duty_slew_ctrl_pkg.sv
// Shared constants and state encoding for the duty slew controller.
// Imported by the interface, the synchroniser and the top.
package duty_slew_ctrl_pkg;
  localparam int DUTY_W     = 6;
  localparam int STEP       = 1;
  localparam int DIV_W      = 4;
  localparam int PWM_PERIOD = 63;

  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    RAMP_UP   = 2'b01,
    RAMP_DOWN = 2'b10
  } state_e;
endpackage

// File: rtl/duty_slew_ctrl_if.sv
// Pad/PWM-side signal bundle for the duty slew controller.
// The bench drives it through master; the controller uses slave.
interface duty_slew_ctrl_if;
  import duty_slew_ctrl_pkg::*;

  logic [DUTY_W-1:0] target_in;
  logic              enable_in;
  logic [DIV_W-1:0]  rate_div;
  logic              period_end;
  logic [DUTY_W-1:0] duty_out;
  logic              busy;
  logic              at_target;

  modport master (
    output target_in, enable_in, rate_div, period_end,
    input  duty_out, busy, at_target
  );

  modport slave (
    input  target_in, enable_in, rate_div, period_end,
    output duty_out, busy, at_target
  );
endinterface

// File: rtl/duty_slew_ctrl_sync2.sv
// Two-flop synchroniser for pad inputs that are asynchronous to clk.
// Both stages clear on reset so the controller starts from a zero target.
module duty_slew_ctrl_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/duty_slew_ctrl.sv
// Slews the PWM duty reference toward the synchronised target, one bounded
// step per divided PWM period, updating only on period boundaries.
module duty_slew_ctrl #(
  parameter int STEP = duty_slew_ctrl_pkg::STEP
) (
  input  logic            clk,
  input  logic            rst_n,
  duty_slew_ctrl_if.slave bus
);
  import duty_slew_ctrl_pkg::*;

  localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);

  logic [DUTY_W-1:0] target_s;
  logic              enable_s;
  logic [DUTY_W-1:0] eff_tgt;

  logic [DIV_W-1:0]  presc_q, presc_d;
  logic              step_tick;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] gap;
  state_e            state_q, state_d;
  logic              busy_q, busy_d;

  duty_slew_ctrl_sync2 #(.WIDTH(DUTY_W)) u_sync_tgt (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.target_in),
    .q     (target_s)
  );

  duty_slew_ctrl_sync2 #(.WIDTH(1)) u_sync_en (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.enable_in),
    .q     (enable_s)
  );

  assign eff_tgt = enable_s ? target_s : '0;

  // >= rather than == so lowering rate_div mid-count still fires promptly.
  always_comb begin
    step_tick = 1'b0;
    presc_d   = presc_q;
    if (bus.period_end) begin
      if (presc_q >= bus.rate_div) begin
        step_tick = 1'b1;
        presc_d   = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    duty_d = duty_q;
    gap    = '0;
    if (step_tick) begin
      if (duty_q < eff_tgt) begin
        gap    = eff_tgt - duty_q;
        duty_d = duty_q + ((gap < STEP_V) ? gap : STEP_V);
      end else if (duty_q > eff_tgt) begin
        gap    = duty_q - eff_tgt;
        duty_d = duty_q - ((gap < STEP_V) ? gap : STEP_V);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD: begin
        if (eff_tgt > duty_q)      state_d = RAMP_UP;
        else if (eff_tgt < duty_q) state_d = RAMP_DOWN;
      end
      RAMP_UP: begin
        if (eff_tgt == duty_q)     state_d = HOLD;
        else if (eff_tgt < duty_q) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (eff_tgt == duty_q)     state_d = HOLD;
        else if (eff_tgt > duty_q) state_d = RAMP_UP;
      end
      default: state_d = HOLD;
    endcase
    busy_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      duty_q  <= '0;
      state_q <= HOLD;
      busy_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      duty_q  <= duty_d;
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.duty_out  = duty_q;
  assign bus.busy      = busy_q;
  assign bus.at_target = (duty_q == eff_tgt);
endmodule

// File: tb/tb_duty_slew_ctrl.sv
// Bench for duty_slew_ctrl: a STEP=1 and a STEP=4 instance share stimulus and
// are checked every cycle against an arithmetic model plus literal pins.
module tb_duty_slew_ctrl;
  import duty_slew_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] targetIn  = 6'd40;
  logic       enableIn  = 1'b1;
  logic [3:0] rateDiv   = 4'd0;
  logic       periodEnd = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  duty_slew_ctrl_if busA ();
  duty_slew_ctrl_if busB ();

  assign busA.target_in  = targetIn;
  assign busA.enable_in  = enableIn;
  assign busA.rate_div   = rateDiv;
  assign busA.period_end = periodEnd;
  assign busB.target_in  = targetIn;
  assign busB.enable_in  = enableIn;
  assign busB.rate_div   = rateDiv;
  assign busB.period_end = periodEnd;

  duty_slew_ctrl #(.STEP(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA.slave));
  duty_slew_ctrl #(.STEP(4)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB.slave));

  // Model state: index 0 tracks the STEP=1 instance, index 1 the STEP=4 one.
  int mDuty [2];
  int mBusy [2];
  int mPresc;
  int s1t, s2t, s1e, s2e;

  function automatic int stepOf(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int approach(int d, int t, int s);
    if (d < t) return d + (((t - d) < s) ? (t - d) : s);
    if (d > t) return d - (((d - t) < s) ? (d - t) : s);
    return d;
  endfunction

  function automatic int effNow();
    return (s2e != 0) ? s2t : 0;
  endfunction

  // Busy reflects whether duty and target differed on the previous cycle.
  always @(posedge clk or negedge rst_n) begin : model
    int  eff;
    bit  tick;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mDuty[i] = 0;
        mBusy[i] = 0;
      end
      mPresc = 0;
      s1t = 0; s2t = 0; s1e = 0; s2e = 0;
    end else begin
      eff  = effNow();
      tick = periodEnd && (mPresc >= int'(rateDiv));
      for (int i = 0; i < 2; i++) begin
        mBusy[i] = (mDuty[i] != eff) ? 1 : 0;
        if (tick) mDuty[i] = approach(mDuty[i], eff, stepOf(i));
      end
      if (periodEnd) mPresc = tick ? 0 : mPresc + 1;
      s2t = s1t;
      s2e = s1e;
      s1t = int'(targetIn);
      s1e = int'(enableIn);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkModel();
    int eff;
    eff = effNow();
    checkOutput("model A duty", int'(busA.duty_out), mDuty[0]);
    checkOutput("model A busy", int'(busA.busy), mBusy[0]);
    checkOutput("model A at_target", int'(busA.at_target), (mDuty[0] == eff) ? 1 : 0);
    checkOutput("model B duty", int'(busB.duty_out), mDuty[1]);
    checkOutput("model B busy", int'(busB.busy), mBusy[1]);
    checkOutput("model B at_target", int'(busB.at_target), (mDuty[1] == eff) ? 1 : 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      checkModel();
    end
  endtask

  task automatic period();
    periodEnd = 1'b0;
    cycles(PWM_PERIOD);
    periodEnd = 1'b1;
    cycles(1);
    periodEnd = 1'b0;
  endtask

  task automatic applyStimulus(input int tgt, input bit en, input int rate);
    targetIn = 6'(tgt);
    enableIn = en;
    rateDiv  = 4'(rate);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3 rst_n = 1'b0;
    $display("[TB] reset with target 40");
    repeat (3) begin
      cycles(1);
      checkOutput("reset duty", int'(busA.duty_out), 0);
      checkOutput("reset busy", int'(busA.busy), 0);
      checkOutput("reset at_target", int'(busA.at_target), 1);
    end
    rst_n = 1'b1;
    cycles(1);
    checkOutput("post-reset busy", int'(busA.busy), 0);

    $display("[TB] ramp up to 5");
    applyStimulus(5, 1'b1, 0);
    for (int k = 1; k <= 5; k++) begin
      period();
      checkOutput("ramp_up duty", int'(busA.duty_out), k);
    end
    cycles(2);
    checkOutput("ramp_up settled busy", int'(busA.busy), 0);
    checkOutput("ramp_up settled at_target", int'(busA.at_target), 1);

    $display("[TB] rate divide by 3");
    applyStimulus(0, 1'b1, 0);
    repeat (5) period();
    checkOutput("rate back to zero", int'(busA.duty_out), 0);
    applyStimulus(3, 1'b1, 2);
    for (int k = 1; k <= 9; k++) begin
      period();
      checkOutput("rate_div duty", int'(busA.duty_out), k / 3);
    end

    $display("[TB] reversal 40 -> 10");
    applyStimulus(40, 1'b1, 0);
    repeat (17) period();
    checkOutput("reversal peak", int'(busA.duty_out), 20);
    applyStimulus(10, 1'b1, 0);
    period();
    checkOutput("reversal first step", int'(busA.duty_out), 19);
    cycles(1);
    checkOutput("reversal busy", int'(busA.busy), 1);
    repeat (14) period();
    checkOutput("reversal settle", int'(busA.duty_out), 10);

    $display("[TB] soft-off and saturation, step 4");
    applyStimulus(6, 1'b1, 0);
    repeat (5) period();
    checkOutput("B start at 6", int'(busB.duty_out), 6);
    applyStimulus(6, 1'b0, 0);
    period();
    checkOutput("B soft-off 2", int'(busB.duty_out), 2);
    period();
    checkOutput("B soft-off 0", int'(busB.duty_out), 0);
    period();
    checkOutput("B soft-off hold", int'(busB.duty_out), 0);
    applyStimulus(61, 1'b1, 0);
    repeat (16) period();
    checkOutput("B at 61", int'(busB.duty_out), 61);
    applyStimulus(63, 1'b1, 0);
    period();
    checkOutput("B saturate 63", int'(busB.duty_out), 63);
    period();
    checkOutput("B no wrap", int'(busB.duty_out), 63);
    checkOutput("B at_target 63", int'(busB.at_target), 1);
    checkOutput("A slow climb", int'(busA.duty_out), 21);

    $display("[TB] async reset mid-ramp");
    applyStimulus(40, 1'b1, 0);
    repeat (9) period();
    checkOutput("A before reset", int'(busA.duty_out), 30);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset A duty", int'(busA.duty_out), 0);
    checkOutput("async reset B duty", int'(busB.duty_out), 0);
    checkOutput("async reset busy", int'(busA.busy), 0);
    cycles(2);
    rst_n = 1'b1;
    repeat (3) period();
    checkOutput("restart A duty", int'(busA.duty_out), 3);
    checkOutput("restart B duty", int'(busB.duty_out), 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
